// File: rtl/tcm_dump_pkg.sv
// Shared types and constants for the TCM dump streamer.
package tcm_dump_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/tcm_dump_fifo_chk.sv
// Overflow checker for the dump FIFO; flags a push into a full FIFO without a pop.
module tcm_dump_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic full
);

    // A push while full is only legal when a pop frees the slot in the same cycle
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/tcm_dump_sync_fifo.sv
// Synchronous FIFO holding read data between the memory port and the output stream.
module tcm_dump_sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    tcm_dump_fifo_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .full  (full)
    );

endmodule

// File: rtl/tcm_dump.sv
// Reads a contiguous word region of a TCM and streams it out on valid/ready.
// Optional checksum trailer beat enabled by defining TCM_DUMP_CHK_EN.
module tcm_dump
    import tcm_dump_pkg::*;
#(
    parameter int AW    = 15,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-2:0] word_cnt,
    output logic          busy,
    output logic          done,
    output logic          mem_req_vld,
    input  logic          mem_req_rdy,
    output logic [AW-1:0] mem_req_addr,
    input  logic          mem_rsp_vld,
    input  logic [DW-1:0] mem_rsp_data,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NW = AW - 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    state_t        state_r;
    state_t        state_s;
    logic [AW-1:0] addr_r;
    logic [NW-1:0] issue_left_r;
    logic [NW-1:0] emit_left_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] fifo_count_s;
    logic [CW:0]   inflight_s;
    logic          done_r;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [DW-1:0] fifo_head_s;
    logic          start_ok_s;
    logic          zero_start_s;
    logic          req_fire_s;
    logic          rsp_push_s;
    logic          data_pop_s;
    logic          last_fire_s;
`ifdef TCM_DUMP_CHK_EN
    logic [DW-1:0] sum_r;
`endif

    assign start_ok_s   = start && (state_r == IDLE) && (word_cnt != '0);
    assign zero_start_s = start && (state_r == IDLE) && (word_cnt == '0);
    assign inflight_s   = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
    assign req_fire_s   = mem_req_vld && mem_req_rdy;
    // Late responses from an aborted dump must not refill the FIFO
    assign rsp_push_s   = mem_rsp_vld && (state_r != IDLE);
    assign data_pop_s   = !fifo_empty_s && out_rdy;
    assign last_fire_s  = out_vld && out_rdy && out_last;
    assign mem_req_addr = addr_r;
    assign done         = done_r;

    // Next state, request credit and output stream muxing
    always_comb begin
        state_s     = state_r;
        busy        = (state_r != IDLE);
        mem_req_vld = 1'b0;
        out_vld     = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        if (!fifo_empty_s) begin
            out_vld  = 1'b1;
            out_data = fifo_head_s;
`ifdef TCM_DUMP_CHK_EN
            out_last = 1'b0;
`else
            out_last = (emit_left_r == NW'(1));
`endif
        end else begin
`ifdef TCM_DUMP_CHK_EN
            // Trailer beat once every data word has left the stream
            if ((state_r == DRAIN) && (emit_left_r == '0)) begin
                out_vld  = 1'b1;
                out_data = sum_r;
                out_last = 1'b1;
            end else begin
                out_vld  = 1'b0;
            end
`else
            out_vld = 1'b0;
`endif
        end
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                mem_req_vld = (issue_left_r != '0) && (inflight_s < DEPTH_L) && !fifo_full_s;
                if (mem_req_vld && mem_req_rdy && (issue_left_r == NW'(1))) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (last_fire_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Address, beat counters, credit tracking and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r        <= '0;
            issue_left_r  <= '0;
            emit_left_r   <= '0;
            outstanding_r <= '0;
            done_r        <= 1'b0;
        end else begin
            done_r <= zero_start_s || last_fire_s;
            if (start_ok_s) begin
                addr_r       <= base_addr & ~AW'(WORD_BYTES - 1);
                issue_left_r <= word_cnt;
                emit_left_r  <= word_cnt;
            end else begin
                if (req_fire_s) begin
                    addr_r       <= addr_r + AW'(WORD_BYTES);
                    issue_left_r <= issue_left_r - NW'(1);
                end
                if (data_pop_s) begin
                    emit_left_r <= emit_left_r - NW'(1);
                end
            end
            case ({req_fire_s, rsp_push_s})
                2'b10:   outstanding_r <= outstanding_r + CW'(1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

`ifdef TCM_DUMP_CHK_EN
    // Running sum of emitted data words, restarted on every accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= '0;
        end else if (start_ok_s) begin
            sum_r <= '0;
        end else if (data_pop_s) begin
            sum_r <= sum_r + fifo_head_s;
        end else begin
            sum_r <= sum_r;
        end
    end
`endif

    tcm_dump_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_push_s),
        .push_data (mem_rsp_data),
        .pop       (data_pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

endmodule

// File: tb/tb_tcm_dump.sv
// Directed bench for tcm_dump: memory responder model, stream scoreboard, checksum aware.
module tb_tcm_dump;

`ifdef TCM_DUMP_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [14:0] base_addr;
    logic [13:0] word_cnt;
    logic        busy;
    logic        done;
    logic        mem_req_vld;
    logic        mem_req_rdy;
    logic [14:0] mem_req_addr;
    logic        mem_rsp_vld;
    logic [31:0] mem_rsp_data;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_data;
    logic        out_last;

    logic [31:0] mem_img [0:8191];
    rsp_t        rq[$];
    beat_t       exp_q[$];
    logic [14:0] req_log[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          done_cnt, done_cyc, beats_seen, first_beat_cyc, last_beat_cyc, start_cyc;
    int          exp_beats;
    int          lat_max = 1;
    logic [31:0] last_data, prev_data;
    bit          prev_stall, busy_seen, req_seen, vld_seen;
    bit          rand_mode = 1'b0;
    bit          out_hold = 1'b0;

    tcm_dump #(.AW(15), .DW(32), .DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .word_cnt     (word_cnt),
        .busy         (busy),
        .done         (done),
        .mem_req_vld  (mem_req_vld),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rsp_data (mem_rsp_data),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder, consumer and stream monitor, all acting on the falling edge
    initial begin
        beat_t b;
        rsp_t  r;
        int    lat;
        mem_req_rdy  = 1'b0;
        mem_rsp_vld  = 1'b0;
        mem_rsp_data = '0;
        out_rdy      = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rq.delete();
                exp_q.delete();
                last_due     = cyc;
                prev_stall   = 1'b0;
                mem_rsp_vld  = 1'b0;
                mem_rsp_data = '0;
                mem_req_rdy  = 1'b0;
                out_rdy      = 1'b0;
                continue;
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                mem_rsp_vld  = 1'b1;
                mem_rsp_data = r.data;
            end else begin
                mem_rsp_vld  = 1'b0;
                mem_rsp_data = '0;
            end
            mem_req_rdy = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_rdy     = out_hold ? 1'b0 : (rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
            busy_seen |= busy;
            req_seen  |= mem_req_vld;
            vld_seen  |= out_vld;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                check_eq("hold_vld", {31'd0, out_vld}, 32'd1);
                check_eq("hold_data", out_data, prev_data);
            end
            prev_stall = out_vld && !out_rdy;
            prev_data  = out_data;
            if (mem_req_vld && mem_req_rdy) begin
                req_log.push_back(mem_req_addr);
                lat = $urandom_range(1, lat_max);
                r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                r.data = mem_img[mem_req_addr[14:2]];
                last_due = r.due;
                rq.push_back(r);
            end
            if (out_vld && out_rdy) begin
                if (beats_seen == 0) first_beat_cyc = cyc;
                beats_seen++;
                last_beat_cyc = cyc;
                if (out_last) last_data = out_data;
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    check_eq("beat_data", out_data, b.data);
                    check_eq("beat_last", {31'd0, out_last}, {31'd0, b.last});
                end
            end
        end
    end

    task automatic run_dump(input logic [14:0] b, input logic [13:0] n);
        logic [31:0] s;
        logic [31:0] w;
        @(negedge clk);
        #1;
        exp_q.delete();
        req_log.delete();
        done_cnt = 0; beats_seen = 0; first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
        busy_seen = 1'b0; req_seen = 1'b0; vld_seen = 1'b0; last_data = '0;
        s = '0;
        for (int k = 0; k < int'(n); k++) begin
            w = mem_img[(int'(b[14:2]) + k) % 8192];
            exp_q.push_back('{w, (k == int'(n) - 1) && !CHK});
            s = s + w;
        end
        if (CHK && n != '0) exp_q.push_back('{s, 1'b1});
        exp_beats = exp_q.size();
        start = 1'b1; base_addr = b; word_cnt = n; start_cyc = cyc;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt != 0) break;
            @(negedge clk);
            #2;
        end
        check_eq({tag, "_done_seen"}, done_cnt, 32'd1);
        check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        #2;
        check_eq({tag, "_done_once"}, done_cnt, 32'd1);
        check_eq({tag, "_beats"}, beats_seen, exp_beats);
        check_eq({tag, "_exp_left"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_req_vld"}, {31'd0, mem_req_vld}, 32'd0);
        check_eq({tag, "_req_addr"}, {17'd0, mem_req_addr}, 32'd0);
        check_eq({tag, "_out_vld"}, {31'd0, out_vld}, 32'd0);
        check_eq({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        check_eq({tag, "_out_data"}, out_data, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0;
        for (int i = 0; i < 8192; i++) mem_img[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0003_0007);
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("rst");
        rst_n = 1'b1;

        // Basic dump: addresses, first-beat latency, done timing
        run_dump(15'h0100, 14'd4);
        wait_done("t1");
        check_eq("t1_nreq", req_log.size(), 32'd4);
        for (int k = 0; k < 4; k++) check_eq("t1_addr", {17'd0, req_log[k]}, 32'h100 + 32'(4 * k));
        check_eq("t1_first_lat", first_beat_cyc - start_cyc, 32'd3);
        check_eq("t1_done_lat", done_cyc - last_beat_cyc, 32'd1);
        check_eq("t1_busy_seen", {31'd0, busy_seen}, 32'd1);

        // Zero-length dump
        run_dump(15'h0200, 14'd0);
        wait_done("t2");
        check_eq("t2_done_lat", done_cyc - start_cyc, 32'd1);
        check_eq("t2_busy_seen", {31'd0, busy_seen}, 32'd0);
        check_eq("t2_req_seen", {31'd0, req_seen}, 32'd0);
        check_eq("t2_vld_seen", {31'd0, vld_seen}, 32'd0);

        // Address wrap at the top of the 15-bit space
        run_dump(15'h7FF8, 14'd4);
        wait_done("t3");
        check_eq("t3_nreq", req_log.size(), 32'd4);
        for (int k = 0; k < 4; k++) check_eq("t3_addr", {17'd0, req_log[k]}, (32'h7FF8 + 32'(4 * k)) & 32'h7FFF);

        // Consumer stall: credit limits issue to DEPTH requests
        out_hold = 1'b1;
        run_dump(15'h0803, 14'd8);
        repeat (20) @(negedge clk);
        #2;
        check_eq("t4_nreq_stall", req_log.size(), 32'd4);
        check_eq("t4_busy_stall", {31'd0, busy}, 32'd1);
        out_hold = 1'b0;
        wait_done("t4");
        check_eq("t4_first_addr", {17'd0, req_log[0]}, 32'h0800);

        // Random handshakes and latency
        rand_mode = 1'b1;
        lat_max   = 3;
        run_dump(15'h2000, 14'd64);
        wait_done("t5");
        check_eq("t5_nreq", req_log.size(), 32'd64);
        check_eq("t5_last_addr", {17'd0, req_log[63]}, 32'h20FC);
        rand_mode = 1'b0;
        lat_max   = 1;

        // Reset mid-RUN, then a clean dump
        out_hold = 1'b1;
        run_dump(15'h0400, 14'd16);
        repeat (10) @(negedge clk);
        #2;
        check_eq("t6_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        @(negedge clk);
        #1;
        rst_n    = 1'b1;
        out_hold = 1'b0;
        run_dump(15'h0040, 14'd5);
        wait_done("t6");
        check_eq("t6_nreq", req_log.size(), 32'd5);
        check_eq("t6_first_addr", {17'd0, req_log[0]}, 32'h0040);

        // Words 1, 2, 3: trailer carries 6 when the checksum is built in
        mem_img[13'h300] = 32'd1;
        mem_img[13'h301] = 32'd2;
        mem_img[13'h302] = 32'd3;
        run_dump(15'h0C00, 14'd3);
        wait_done("t7");
        check_eq("t7_last_data", last_data, CHK ? 32'd6 : 32'd3);
        check_eq("t7_beats", beats_seen, CHK ? 32'd4 : 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tcm_dump.md
Name: tcm_dump

Overview:
- Reader/streamer counterpart to program loading into ITCM.
- On a start pulse, reads a contiguous word region of a TCM through a simple req/rsp memory port and emits each word on a valid/ready output stream.
- Used for DTCM signature extraction and for ITCM readback checks.
- Sits beside the TCM arbiter in the SoC; the sim top drives start/base/count and drains the stream.

Parameters:
- AW, 15, TCM byte-address width.
- DW, 32, data word width (fixed 32 for byte-address stride 4).
- DEPTH, 4, maximum outstanding reads plus buffered words (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a dump; ignored while busy
- base_addr  in  AW  start byte address, bits [1:0] ignored (treated 0)
- word_cnt  in  AW-1  number of words to dump, sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last beat is accepted (or at once for word_cnt=0)
- mem_req_vld  out  1  read request valid
- mem_req_rdy  in  1  memory accepts request
- mem_req_addr  out  AW  word-aligned byte address
- mem_rsp_vld  in  1  read data valid; in request order, latency >=1, no backpressure
- mem_rsp_data  in  DW  read data
- out_vld  out  1  stream beat valid
- out_rdy  in  1  consumer ready
- out_data  out  DW  stream data
- out_last  out  1  marks final beat

Behaviour:
- Reset: busy=0, done=0, mem_req_vld=0, mem_req_addr=0, out_vld=0, out_last=0, out_data=0; FSM IDLE; all counters and FIFO cleared. A reset mid-dump aborts it; no further requests are issued.
- FSM states:
  - IDLE: start with word_cnt!=0 latches addr=base_addr&~3, issue_left=word_cnt, emit_left=word_cnt, goes to RUN, busy=1 next cycle. start with word_cnt=0 pulses done next cycle and stays IDLE; busy stays 0.
  - RUN: mem_req_vld=1 when issue_left!=0 and (outstanding + fifo_count) < DEPTH. Request fires on vld&rdy: addr+=4, issue_left-=1, outstanding+=1. When issue_left reaches 0, go to DRAIN.
  - DRAIN: no requests; wait for all responses and stream beats.
  - Leaving DRAIN: once emit_left reaches 0, done pulses the cycle after the last out handshake; go to IDLE, busy=0 in that same cycle.
- Address wrap: addr increments modulo 2^AW and silently wraps to 0.
- Responses: each mem_rsp_vld pushes mem_rsp_data into the FIFO and decrements outstanding. Simultaneous push and pop are legal. The credit rule guarantees the FIFO never overflows; an overflow is an assertion failure.
- Output: out_vld = FIFO not empty; out_data = FIFO head. out_last = 1 on the beat where emit_left==1. Each out_vld&out_rdy pops and decrements emit_left.
- Output hold: out_vld/out_data stay stable while out_rdy=0.
- Latency: with mem latency 1 and out_rdy=1, the first out beat is 3 cycles after start; one beat per cycle thereafter.
- Counter widths: outstanding and fifo_count are $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: TCM_DUMP_CHK_EN.
- Defined: keeps a DW-bit running sum (mod 2^DW) of all emitted data words and appends one extra beat carrying that sum. out_last moves to the checksum beat; done follows its handshake. For word_cnt=0 nothing is emitted.
- Undefined: no checksum logic, and the stream carries exactly word_cnt beats.

Decomposition:
- Package tcm_dump_pkg: FSM state enum (IDLE, RUN, DRAIN), WORD_BYTES=4 constant.
- Sub-module sync_fifo (DW wide, DEPTH deep, push/pop/empty/full/count) instantiated once.

Test Plan:
- base=0x0100, cnt=4, mem latency 1, out_rdy=1 -> requests to 0x100, 0x104, 0x108, 0x10C; 4 beats with the preloaded words; out_last on beat 4; done one cycle later.
- cnt=0 -> done pulse next cycle; busy, mem_req_vld and out_vld stay 0.
- base=0x7FF8, cnt=4, AW=15 -> addresses 0x7FF8, 0x7FFC, 0x0000, 0x0004.
- out_rdy=0 for 20 cycles, cnt=8, DEPTH=4 -> exactly 4 requests issued, then stall; data ordered and intact after release.
- Random mem_req_rdy and out_rdy, random latency 1-3, cnt=64 -> stream equals memory image in order, no FIFO overflow assertion.
- Assert rst_n low mid-RUN -> all outputs 0 next edge; a new start after reset dumps correctly. With TCM_DUMP_CHK_EN, words 1, 2, 3 -> 4th beat = 6 with out_last.
